rx_iq_frame_buf: RTL and testbench

- Parametrised RX sample front end: accepts raw ADC I/Q words, widens them to the processing width, buffers them in a FIFO and streams them out with valid/ready backpressure.
- Output is tagged with start/end-of-frame markers every FRAME_LEN samples.
- Sits between the ADC interface (fromADC_*) and the RX signal-processing chain, replacing the fixed 12-to-16-bit, always-ready input path.

---
 rtl/rx_iq_frame_buf.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_rx_iq_frame_buf.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_iq_frame_buf.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// rx_iq_frame_buf
//
// RX sample front end. It takes raw ADC I/Q words and widens each rail from
// IN_W to OUT_W bits. The widened samples go into a FIFO of DEPTH entries and
// leave it on a valid/ready stream. The stream is tagged with start-of-frame
// and end-of-frame markers every FRAME_LEN samples.
//
// Optional build macro:
//   RX_LEFT_JUSTIFY_EN  when defined, each rail is left-justified:
//                       {sample, zeros}, for full-scale output.
//                       When undefined, each rail is sign-extended.
//
// Ports:
//   i_clk      sample clock, the only clock
//   i_rst_n    asynchronous active-low reset (async assert, sync release)
//   i_en       capture enable
//   i_clr      synchronous pulse that clears o_ovf
//   i_in_i     ADC I sample, two's complement, IN_W bits
//   i_in_q     ADC Q sample, two's complement, IN_W bits
//   i_in_vld   input sample valid; the input has no backpressure
//   o_out_i    widened I sample, OUT_W bits
//   o_out_q    widened Q sample, OUT_W bits
//   o_out_vld  output valid
//   i_out_rdy  downstream ready; a transfer happens on o_out_vld && i_out_rdy
//   o_sof      first sample of a frame (qualified by o_out_vld)
//   o_eof      last sample of a frame, or last sample of a truncated frame
//   o_ovf      sticky overflow flag, set when a sample is dropped
//   o_level    FIFO occupancy, 0..DEPTH (this count includes the output stage)
//   o_busy     high whenever the controller is not IDLE
// ---------------------------------------------------------------------------
module rx_iq_frame_buf #(
    parameter int IN_W      = 12,
    parameter int OUT_W     = 16,
    parameter int DEPTH     = 64,
    parameter int FRAME_LEN = 256
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic                     i_clr,
    input  logic [IN_W-1:0]          i_in_i,
    input  logic [IN_W-1:0]          i_in_q,
    input  logic                     i_in_vld,
    output logic [OUT_W-1:0]         o_out_i,
    output logic [OUT_W-1:0]         o_out_q,
    output logic                     o_out_vld,
    input  logic                     i_out_rdy,
    output logic                     o_sof,
    output logic                     o_eof,
    output logic                     o_ovf,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int FW = $clog2(FRAME_LEN);
    localparam int EW = 2 + 2 * OUT_W;   // {sof, eof, I, Q}

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t state_reg;
    logic   busy_reg;

    // -----------------------------------------------------------------------
    // Widening. Both rails go through the same generated path.
    // -----------------------------------------------------------------------
    logic [IN_W-1:0]  raw_rail  [2];
    logic [OUT_W-1:0] wide_rail [2];

    assign raw_rail[0] = i_in_i;
    assign raw_rail[1] = i_in_q;

    for (genvar gi = 0; gi < 2; gi++) begin : g_widen
`ifdef RX_LEFT_JUSTIFY_EN
        // Place the sample in the MSBs and zero-fill the LSBs.
        assign wide_rail[gi] = OUT_W'(raw_rail[gi]) << (OUT_W - IN_W);
`else
        // Sign-extend the two's complement sample into the wider word.
        assign wide_rail[gi] = OUT_W'($signed(raw_rail[gi]));
`endif
    end

    // -----------------------------------------------------------------------
    // FIFO storage. The registered output stage holds the head entry. The RAM
    // holds the entries queued behind the head. o_level counts both, so the
    // RAM never has to hold more than DEPTH-1 entries.
    // -----------------------------------------------------------------------
    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    mem_cnt_reg;
    logic [LW-1:0]    level_reg;
    logic             ovf_reg;
    logic [FW-1:0]    fcnt_reg;

    logic             out_vld_reg;
    logic             out_sof_reg;
    logic             out_eof_reg;
    logic [OUT_W-1:0] out_i_reg;
    logic [OUT_W-1:0] out_q_reg;

    logic             wr_state_ok;
    logic             rd_fire;
    logic             full;
    logic             wr_fire;
    logic             ovf_event;
    logic             out_free;
    logic             load_from_mem;
    logic             load_bypass;
    logic             mem_wr;
    logic             wr_sof;
    logic             wr_eof;
    logic [EW-1:0]    wr_word;
    logic             drain_done;

    // Writes are only accepted while armed or running, and only with i_en high.
    // In RUN the cycle where i_en drops never writes.
    assign wr_state_ok = i_en && i_in_vld &&
                         ((state_reg == ST_ARMED) || (state_reg == ST_RUN));
    assign rd_fire     = out_vld_reg && i_out_rdy;
    assign full        = (level_reg == LW'(DEPTH));

    // When the FIFO is full, a read in the same cycle frees a slot, so the
    // write is still accepted.
    assign wr_fire     = wr_state_ok && (!full || rd_fire);
    assign ovf_event   = wr_state_ok && full && !rd_fire;

    assign wr_sof      = (fcnt_reg == '0);
    assign wr_eof      = (fcnt_reg == FW'(FRAME_LEN - 1));
    assign wr_word     = {wr_sof, wr_eof, wide_rail[0], wide_rail[1]};

    // The output stage can take a new entry when it is empty or being read.
    // The RAM has priority. A new sample skips the RAM only when the RAM is
    // empty, which gives one-cycle latency through an empty FIFO.
    assign out_free      = !out_vld_reg || rd_fire;
    assign load_from_mem = out_free && (mem_cnt_reg != '0);
    assign load_bypass   = out_free && (mem_cnt_reg == '0) && wr_fire;
    assign mem_wr        = wr_fire && !load_bypass;

    assign drain_done    = (state_reg == ST_DRAIN) && (level_reg == '0);

    // RAM write port. It has no reset, so it can map onto block RAM.
    always_ff @(posedge i_clk) begin
        if (mem_wr) begin
            mem[wr_ptr_reg] <= wr_word;
        end
    end

    // Pointers, occupancy, output stage, overflow flag and frame counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            mem_cnt_reg <= '0;
            level_reg   <= '0;
            ovf_reg     <= 1'b0;
            fcnt_reg    <= '0;
            out_vld_reg <= 1'b0;
            out_sof_reg <= 1'b0;
            out_eof_reg <= 1'b0;
            out_i_reg   <= '0;
            out_q_reg   <= '0;
        end else begin
            if (mem_wr) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end

            // Registered read from the RAM into the output stage.
            if (load_from_mem) begin
                {out_sof_reg, out_eof_reg, out_i_reg, out_q_reg} <= mem[rd_ptr_reg];
                rd_ptr_reg  <= rd_ptr_reg + AW'(1);
                out_vld_reg <= 1'b1;
            end else if (load_bypass) begin
                {out_sof_reg, out_eof_reg, out_i_reg, out_q_reg} <= wr_word;
                out_vld_reg <= 1'b1;
            end else if (rd_fire) begin
                out_vld_reg <= 1'b0;
            end

            unique case ({mem_wr, load_from_mem})
                2'b10:   mem_cnt_reg <= mem_cnt_reg + LW'(1);
                2'b01:   mem_cnt_reg <= mem_cnt_reg - LW'(1);
                default: mem_cnt_reg <= mem_cnt_reg;
            endcase

            unique case ({wr_fire, rd_fire})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase

            // A new overflow beats a clear in the same cycle.
            if (ovf_event) begin
                ovf_reg <= 1'b1;
            end else if (i_clr) begin
                ovf_reg <= 1'b0;
            end

            // The frame counter restarts whenever the controller finishes a
            // drain or is idle, so every run starts on a fresh frame.
            if ((state_reg == ST_IDLE) || drain_done) begin
                fcnt_reg <= '0;
            end else if (wr_fire) begin
                if (fcnt_reg == FW'(FRAME_LEN - 1)) begin
                    fcnt_reg <= '0;
                end else begin
                    fcnt_reg <= fcnt_reg + FW'(1);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Capture controller.
    //   IDLE  -> ARMED  when i_en goes high
    //   ARMED -> RUN    on the first valid sample (that sample is written)
    //   ARMED -> IDLE   when i_en drops
    //   RUN   -> DRAIN  when i_en drops
    //   DRAIN -> IDLE   once the FIFO is empty; i_en is ignored until then
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (i_en) begin
                        state_reg <= ST_ARMED;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (!i_en) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else if (i_in_vld) begin
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!i_en) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (level_reg == '0) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign o_out_i   = out_i_reg;
    assign o_out_q   = out_q_reg;
    assign o_out_vld = out_vld_reg;
    assign o_sof     = out_sof_reg;
    // A truncated frame still ends with eof: the last entry left during a
    // drain is marked as the end of the frame.
    assign o_eof     = out_eof_reg ||
                       ((state_reg == ST_DRAIN) && (level_reg == LW'(1)) && out_vld_reg);
    assign o_ovf     = ovf_reg;
    assign o_level   = level_reg;
    assign o_busy    = busy_reg;

endmodule

// File: tb/tb_rx_iq_frame_buf.sv
`timescale 1ns/1ps
module tb_rx_iq_frame_buf;

    localparam int DEPTH = 4;
    localparam int FL    = 4;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_RUN   = 2;
    localparam int M_DRAIN = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic [11:0] in_i = '0;
    logic [11:0] in_q = '0;
    logic        in_vld = 1'b0;
    logic        out_rdy = 1'b0;
    logic [15:0] out_i;
    logic [15:0] out_q;
    logic        out_vld;
    logic        sof;
    logic        eof;
    logic        ovf;
    logic [2:0]  level;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        bit          sof;
        bit          eof;
        logic [15:0] i;
        logic [15:0] q;
    } smp_t;

    // Reference model: a queue of samples in flight plus the frame and
    // controller rules.
    smp_t m_q[$];
    int   m_fcnt = 0;
    bit   m_ovf  = 1'b0;
    int   m_st   = M_IDLE;

    // Samples observed leaving the DUT in the current test.
    smp_t obs[$];

    rx_iq_frame_buf #(
        .IN_W(12), .OUT_W(16), .DEPTH(DEPTH), .FRAME_LEN(FL)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clr(clr),
        .i_in_i(in_i), .i_in_q(in_q), .i_in_vld(in_vld),
        .o_out_i(out_i), .o_out_q(out_q), .o_out_vld(out_vld),
        .i_out_rdy(out_rdy), .o_sof(sof), .o_eof(eof), .o_ovf(ovf),
        .o_level(level), .o_busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time=%0t required finish before 500000", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] widen(input logic [11:0] raw);
`ifdef RX_LEFT_JUSTIFY_EN
        return {raw, 4'h0};
`else
        int v;
        v = int'(raw);
        if (v >= 2048) v = v - 4096;
        return 16'(v);
`endif
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_fcnt = 0;
        m_ovf  = 1'b0;
        m_st   = M_IDLE;
    endtask

    // Applies the effect of one clock edge, given the inputs for this cycle.
    task automatic model_step(input bit e, input bit v, input bit r, input bit c,
                              input logic [11:0] ri, input logic [11:0] rq);
        int   sz;
        bit   rd;
        bit   wr_ok;
        bit   acc;
        smp_t s;
        sz    = m_q.size();
        rd    = (sz > 0) && r;
        wr_ok = e && v && (m_st == M_ARMED || m_st == M_RUN);
        acc   = wr_ok && (sz < DEPTH || rd);
        if (rd) m_q.delete(0);
        if (acc) begin
            s.sof = (m_fcnt == 0);
            s.eof = (m_fcnt == FL - 1);
            s.i   = widen(ri);
            s.q   = widen(rq);
            m_q.push_back(s);
            m_fcnt = (m_fcnt + 1) % FL;
        end
        if (wr_ok && !acc) m_ovf = 1'b1;
        else if (c)        m_ovf = 1'b0;
        case (m_st)
            M_IDLE:  begin m_fcnt = 0; if (e) m_st = M_ARMED; end
            M_ARMED: begin if (!e) m_st = M_IDLE; else if (v) m_st = M_RUN; end
            M_RUN:   begin if (!e) m_st = M_DRAIN; end
            default: begin if (sz == 0) begin m_st = M_IDLE; m_fcnt = 0; end end
        endcase
    endtask

    // Called at a falling edge: drives the inputs, advances the model, and
    // returns at the next falling edge.
    task automatic step_cycle(input bit e, input bit v, input bit r, input bit c,
                              input logic [11:0] ri, input logic [11:0] rq);
        en = e; in_vld = v; out_rdy = r; clr = c; in_i = ri; in_q = rq;
        model_step(e, v, r, c, ri, rq);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic note_xfer(input string tag);
        smp_t s;
        s.sof = sof; s.eof = eof; s.i = out_i; s.q = out_q;
        obs.push_back(s);
        $display("xfer %s n=%0d i=%h q=%h sof=%0b eof=%0b", tag, obs.size() - 1,
                 out_i, out_q, sof, eof);
    endtask

    task automatic drain_to_idle(input string tag);
        int n;
        n = 0;
        while (m_st != M_IDLE && n < 40) begin
            step_cycle(1'b0, 1'b0, 1'b1, 1'b0, 12'h0, 12'h0);
            n++;
        end
        n_cmp++;
        if (busy !== 1'b0 || level !== 3'd0) begin
            n_fail++;
            $display("FAIL %s_drain busy=%0b level=%0d required busy=0 level=0", tag, busy, level);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({out_vld, sof, eof, ovf, busy} !== 5'b0 || level !== 3'd0 ||
            out_i !== 16'h0 || out_q !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs vld=%0b sof=%0b eof=%0b ovf=%0b busy=%0b level=%0d i=%h q=%h required all 0",
                     out_vld, sof, eof, ovf, busy, level, out_i, out_q);
        end
        rst_n = 1'b1;
        step_cycle(1'b0, 1'b1, 1'b1, 1'b0, 12'h123, 12'h456);
        n_cmp++;
        if (out_vld !== 1'b0 || busy !== 1'b0 || level !== 3'd0) begin
            n_fail++;
            $display("FAIL idle_no_write vld=%0b busy=%0b level=%0d required 0 0 0", out_vld, busy, level);
        end
    endtask

    task automatic test_widening();
        logic [15:0] exp_i;
        logic [15:0] exp_q;
`ifdef RX_LEFT_JUSTIFY_EN
        exp_i = 16'h8000; exp_q = 16'h7FF0;
`else
        exp_i = 16'hF800; exp_q = 16'h07FF;
`endif
        step_cycle(1'b1, 1'b0, 1'b1, 1'b0, 12'h0, 12'h0);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL armed_busy got=%0b required=1", busy);
        end
        step_cycle(1'b1, 1'b1, 1'b1, 1'b0, 12'h800, 12'h7FF);
        n_cmp++;
        if (out_vld !== 1'b1 || out_i !== exp_i || out_q !== exp_q || sof !== 1'b1 || level !== 3'd1) begin
            n_fail++;
            $display("FAIL widen_latency vld=%0b i=%h q=%h sof=%0b level=%0d required 1 %h %h 1 1",
                     out_vld, out_i, out_q, sof, level, exp_i, exp_q);
        end
        drain_to_idle("widen");
    endtask

    task automatic test_frame_markers();
        obs.delete();
        step_cycle(1'b1, 1'b0, 1'b1, 1'b0, 12'h0, 12'h0);
        for (int c = 0; c < 12; c++) begin
            if (out_vld) note_xfer("frame");
            step_cycle(c < 10, c < 10, 1'b1, 1'b0, 12'(12'h300 + c), 12'(12'h0F0 - c));
        end
        n_cmp++;
        if (obs.size() != 10) begin
            n_fail++;
            $display("FAIL frame_count got=%0d required=10", obs.size());
        end
        for (int k = 0; k < obs.size() && k < 10; k++) begin
            n_cmp++;
            if (obs[k].sof !== (k % 4 == 0) || obs[k].eof !== (k % 4 == 3) ||
                obs[k].i !== widen(12'(12'h300 + k))) begin
                n_fail++;
                $display("FAIL frame_marker k=%0d sof=%0b eof=%0b i=%h required %0b %0b %h",
                         k, obs[k].sof, obs[k].eof, obs[k].i, (k % 4 == 0), (k % 4 == 3),
                         widen(12'(12'h300 + k)));
            end
        end
        drain_to_idle("frame");
    endtask

    task automatic test_overflow();
        obs.delete();
        step_cycle(1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 12'h0);
        for (int k = 1; k <= 6; k++) begin
            step_cycle(1'b1, 1'b1, 1'b0, 1'b0, 12'(12'hF00 + k), 12'(12'h010 + k));
            if (k == 4) begin
                n_cmp++;
                if (level !== 3'd4 || ovf !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovf_fill4 level=%0d ovf=%0b required 4 0", level, ovf);
                end
            end
            if (k == 5) begin
                n_cmp++;
                if (level !== 3'd4 || ovf !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ovf_after5 level=%0d ovf=%0b required 4 1", level, ovf);
                end
            end
        end
        for (int c = 0; c < 8; c++) begin
            if (out_vld) note_xfer("ovf");
            step_cycle(1'b1, 1'b0, 1'b1, 1'b0, 12'h0, 12'h0);
        end
        n_cmp++;
        if (obs.size() != 4) begin
            n_fail++;
            $display("FAIL ovf_out_count got=%0d required=4", obs.size());
        end
        for (int k = 0; k < obs.size() && k < 4; k++) begin
            n_cmp++;
            if (obs[k].i !== widen(12'(12'hF01 + k)) || obs[k].q !== widen(12'(12'h011 + k))) begin
                n_fail++;
                $display("FAIL ovf_data k=%0d i=%h q=%h required %h %h", k, obs[k].i, obs[k].q,
                         widen(12'(12'hF01 + k)), widen(12'(12'h011 + k)));
            end
        end
        n_cmp++;
        if (ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky got=%0b required=1", ovf);
        end
        step_cycle(1'b1, 1'b0, 1'b1, 1'b1, 12'h0, 12'h0);
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear got=%0b required=0", ovf);
        end
        drain_to_idle("ovf");
    endtask

    task automatic test_full_rw();
        obs.delete();
        step_cycle(1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 12'h0);
        for (int k = 0; k < 4; k++)
            step_cycle(1'b1, 1'b1, 1'b0, 1'b0, 12'(12'h040 + k), 12'(12'hC00 + k));
        for (int k = 4; k < 10; k++) begin
            if (out_vld) note_xfer("fullrw");
            step_cycle(1'b1, 1'b1, 1'b1, 1'b0, 12'(12'h040 + k), 12'(12'hC00 + k));
            n_cmp++;
            if (level !== 3'd4 || ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL fullrw_level k=%0d level=%0d ovf=%0b required 4 0", k, level, ovf);
            end
        end
        for (int c = 0; c < 10; c++) begin
            if (out_vld) note_xfer("fullrw");
            step_cycle(1'b1, 1'b0, 1'b1, 1'b0, 12'h0, 12'h0);
        end
        n_cmp++;
        if (obs.size() != 10) begin
            n_fail++;
            $display("FAIL fullrw_count got=%0d required=10", obs.size());
        end
        for (int k = 0; k < obs.size() && k < 10; k++) begin
            n_cmp++;
            if (obs[k].i !== widen(12'(12'h040 + k)) || obs[k].q !== widen(12'(12'hC00 + k))) begin
                n_fail++;
                $display("FAIL fullrw_data k=%0d i=%h q=%h required %h %h", k, obs[k].i, obs[k].q,
                         widen(12'(12'h040 + k)), widen(12'(12'hC00 + k)));
            end
        end
        drain_to_idle("fullrw");
    endtask

    task automatic test_partial_drain();
        int  wr;
        bit  rdy_v;
        bit  saw_zero;
        bit  done;
        obs.delete();
        wr = 0; saw_zero = 1'b0; done = 1'b0;
        step_cycle(1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 12'h0);
        for (int c = 0; c < 12; c++) begin
            rdy_v = (c % 4 != 3);
            if (out_vld && rdy_v) note_xfer("part");
            step_cycle(1'b1, (c % 2 == 0), rdy_v, 1'b0, 12'(12'h020 + wr), 12'(12'h0A0 + wr));
            if (c % 2 == 0) wr++;
        end
        step_cycle(1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 12'h0);
        for (int c = 0; c < 40 && !done; c++) begin
            rdy_v = (c % 2 == 1);
            if (saw_zero) begin
                n_cmp++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL part_busy_fall got=%0b required=0", busy);
                end
                done = 1'b1;
            end else begin
                if (level == 3'd0) begin
                    n_cmp++;
                    if (busy !== 1'b1) begin
                        n_fail++;
                        $display("FAIL part_busy_hold got=%0b required=1", busy);
                    end
                    saw_zero = 1'b1;
                end
                if (out_vld && rdy_v) note_xfer("part");
                step_cycle(1'b0, 1'b0, rdy_v, 1'b0, 12'h0, 12'h0);
            end
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL part_timeout busy=%0b level=%0d required idle within 40 cycles", busy, level);
        end
        n_cmp++;
        if (obs.size() != 6) begin
            n_fail++;
            $display("FAIL part_count got=%0d required=6", obs.size());
        end
        for (int k = 0; k < obs.size() && k < 6; k++) begin
            n_cmp++;
            if (obs[k].sof !== (k % 4 == 0) || obs[k].eof !== (k % 4 == 3 || k == 5) ||
                obs[k].i !== widen(12'(12'h020 + k))) begin
                n_fail++;
                $display("FAIL part_marker k=%0d sof=%0b eof=%0b i=%h required %0b %0b %h", k,
                         obs[k].sof, obs[k].eof, obs[k].i, (k % 4 == 0), (k % 4 == 3 || k == 5),
                         widen(12'(12'h020 + k)));
            end
        end
        step_cycle(1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 12'h0);
        step_cycle(1'b1, 1'b1, 1'b0, 1'b0, 12'h555, 12'h2AA);
        n_cmp++;
        if (out_vld !== 1'b1 || sof !== 1'b1) begin
            n_fail++;
            $display("FAIL part_next_sof vld=%0b sof=%0b required 1 1", out_vld, sof);
        end
        drain_to_idle("part");
    endtask

    task automatic test_reset_midstream();
        step_cycle(1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 12'h0);
        for (int k = 0; k < 5; k++)
            step_cycle(1'b1, 1'b1, 1'b0, 1'b0, 12'(12'h700 + k), 12'(12'h100 + k));
        step_cycle(1'b1, 1'b0, 1'b1, 1'b0, 12'h0, 12'h0);
        n_cmp++;
        if (level !== 3'd3 || ovf !== 1'b1 || out_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre level=%0d ovf=%0b vld=%0b required 3 1 1", level, ovf, out_vld);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_vld !== 1'b0 || level !== 3'd0 || ovf !== 1'b0 || busy !== 1'b0 || out_i !== 16'h0) begin
            n_fail++;
            $display("FAIL rstmid_async vld=%0b level=%0d ovf=%0b busy=%0b i=%h required 0 0 0 0 0000",
                     out_vld, level, ovf, busy, out_i);
        end
        model_reset();
        en = 1'b0; in_vld = 1'b0; out_rdy = 1'b0; clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        bit en_r;
        bit v;
        bit r;
        bit c;
        bit ev;
        bit exp_eof;
        en_r = 1'b1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            ev = (m_q.size() > 0);
            n_cmp++;
            if (out_vld !== ev || level !== 3'(m_q.size()) || ovf !== m_ovf ||
                busy !== (m_st != M_IDLE)) begin
                n_fail++;
                $display("FAIL rnd_status cyc=%0d vld=%0b level=%0d ovf=%0b busy=%0b required %0b %0d %0b %0b",
                         cyc, out_vld, level, ovf, busy, ev, m_q.size(), m_ovf, (m_st != M_IDLE));
            end
            if (ev) begin
                exp_eof = m_q[0].eof || (m_st == M_DRAIN && m_q.size() == 1);
                n_cmp++;
                if (out_i !== m_q[0].i || out_q !== m_q[0].q || sof !== m_q[0].sof || eof !== exp_eof) begin
                    n_fail++;
                    $display("FAIL rnd_data cyc=%0d i=%h q=%h sof=%0b eof=%0b required %h %h %0b %0b",
                             cyc, out_i, out_q, sof, eof, m_q[0].i, m_q[0].q, m_q[0].sof, exp_eof);
                end
            end
            if ($urandom_range(0, 29) == 0) en_r = !en_r;
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 1) == 1);
            c = ($urandom_range(0, 15) == 0);
            if (out_vld && r) note_xfer("rnd");
            step_cycle(en_r, v, r, c, 12'($urandom), 12'($urandom));
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_widening();
        test_frame_markers();
        test_overflow();
        test_full_rw();
        test_partial_drain();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
